// File: rtl/post_state_mac_serial.sv
// post_state_mac_serial
// Serial Kalman posterior-state update: x_post = x_prior + K * (z_meas - z_hat).
// A single N x N signed multiplier walks K one element per cycle into a wide
// accumulator. Each row of X_POST is written as soon as it is complete.
// Optional build macro POST_STATE_SAT_EN: when defined, the innovation
// reduction and the final output selection saturate instead of wrapping.
// Latency is the same in both builds.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// ERR   | compute innovation e[j] = z_meas[j] - z_hat[j], clear accumulator
// MAC   | acc += K(i,j) * e[j], one j per cycle
// WB    | write X_POST[i] = select(acc + x_prior[i] << FRAC), next row or finish

module post_state_mac_serial #(
    parameter int N    = 20,
    parameter int FRAC = 10,
    parameter int NX   = 2,
    parameter int NZ   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NX*N-1:0]     x_prior,
    input  logic [NZ*N-1:0]     z_meas,
    input  logic [NZ*N-1:0]     z_hat,
    input  logic [NX*NZ*N-1:0]  k,
    output logic                busy,
    output logic                done,
    output logic [NX*N-1:0]     X_POST
);

    localparam int AW = 2*N + $clog2(NZ) + 1;
    localparam int IW = (NX > 1) ? $clog2(NX) : 1;
    localparam int JW = (NZ > 1) ? $clog2(NZ) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(NX - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NZ - 1);
    localparam logic [N-1:0]  W_MAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  W_MIN  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERR,
        S_MAC,
        S_WB
    } state_t;

    state_t              state;
    logic [NX*N-1:0]     x_reg;
    logic [NZ*N-1:0]     zm_reg;
    logic [NZ*N-1:0]     zh_reg;
    logic [NX*NZ*N-1:0]  k_reg;
    logic [NZ*N-1:0]     e_reg;
    logic [NZ*N-1:0]     e_next;
    logic [IW-1:0]       i_idx;
    logic [JW-1:0]       j_idx;
    logic [AW-1:0]       acc;

    logic [N-1:0]        k_sel;
    logic [N-1:0]        e_sel;
    logic [N-1:0]        x_sel;
    logic signed [2*N-1:0] prod;
    logic [N-1:0]        row_val;

    // Innovation reduction from the N+1-bit difference down to N bits.
    function automatic logic [N-1:0] err_reduce(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef POST_STATE_SAT_EN
        logic [N:0] d;
        d = {a[N-1], a} - {b[N-1], b};
        if (d[N] != d[N-1])
            return d[N] ? W_MIN : W_MAX;
        return d[N-1:0];
`else
        return a - b;
`endif
    endfunction

    assign k_sel = k_reg[(int'(i_idx)*NZ + int'(j_idx))*N +: N];
    assign e_sel = e_reg[int'(j_idx)*N +: N];
    assign x_sel = x_reg[int'(i_idx)*N +: N];
    assign prod  = $signed(k_sel) * $signed(e_sel);

    // Innovation vector from the captured measurements.
    always_comb begin
        e_next = '0;
        for (int jj = 0; jj < NZ; jj++)
            e_next[jj*N +: N] = err_reduce(zm_reg[jj*N +: N], zh_reg[jj*N +: N]);
    end

    // Row result: the prior term has zero fractional bits, so adding it above
    // the FRAC boundary is identical to adding (x << FRAC) to the full sum.
`ifdef POST_STATE_SAT_EN
    logic [AW-FRAC-1:0] hi_sum;
    logic [AW-FRAC-N:0] hi_top;
    always_comb begin
        hi_sum  = acc[AW-1:FRAC] + {{(AW-FRAC-N){x_sel[N-1]}}, x_sel};
        hi_top  = hi_sum[AW-FRAC-1:N-1];
        row_val = hi_sum[N-1:0];
        if (!((&hi_top) || (~|hi_top)))
            row_val = hi_sum[AW-FRAC-1] ? W_MIN : W_MAX;
    end
`else
    // Wrapping selection of result bits [FRAC+N-1:FRAC].
    always_comb begin
        row_val = acc[FRAC+N-1:FRAC] + x_sel;
    end
`endif

    // Sequencer, operand capture, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            x_reg  <= '0;
            zm_reg <= '0;
            zh_reg <= '0;
            k_reg  <= '0;
            e_reg  <= '0;
            i_idx  <= '0;
            j_idx  <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            X_POST <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                i_idx <= '0;
                j_idx <= '0;
                acc   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            x_reg  <= x_prior;
                            zm_reg <= z_meas;
                            zh_reg <= z_hat;
                            k_reg  <= k;
                            i_idx  <= '0;
                            j_idx  <= '0;
                            busy   <= 1'b1;
                            state  <= S_ERR;
                        end
                    end
                    S_ERR: begin
                        e_reg <= e_next;
                        acc   <= '0;
                        state <= S_MAC;
                    end
                    S_MAC: begin
                        acc <= acc + {{(AW-2*N){prod[2*N-1]}}, prod};
                        if (j_idx == J_LAST)
                            state <= S_WB;
                        else
                            j_idx <= j_idx + 1'b1;
                    end
                    S_WB: begin
                        X_POST[int'(i_idx)*N +: N] <= row_val;
                        acc   <= '0;
                        j_idx <= '0;
                        if (i_idx == I_LAST) begin
                            i_idx <= '0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            i_idx <= i_idx + 1'b1;
                            state <= S_MAC;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_post_state_mac_serial.sv
// Testbench for post_state_mac_serial: default 2x2 instance plus a 3x1 instance.
// Expected vectors are pushed to per-instance queues at start; monitors pop and
// compare whenever done is seen.
module tb_post_state_mac_serial;

    localparam int N    = 20;
    localparam int FRAC = 10;
    localparam longint MAXV = (longint'(1) << (N-1)) - 1;
    localparam longint MINV = -(longint'(1) << (N-1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start, abort, busy, done;
    logic [2*N-1:0] x_prior, z_meas, z_hat, X_POST;
    logic [4*N-1:0] k;

    logic           start3, abort3, busy3, done3;
    logic [3*N-1:0] x3, k3, xp3;
    logic [N-1:0]   z3, zh3;

    post_state_mac_serial #(.N(N), .FRAC(FRAC), .NX(2), .NZ(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_prior(x_prior), .z_meas(z_meas), .z_hat(z_hat), .k(k),
        .busy(busy), .done(done), .X_POST(X_POST)
    );

    post_state_mac_serial #(.N(N), .FRAC(FRAC), .NX(3), .NZ(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .x_prior(x3), .z_meas(z3), .z_hat(zh3), .k(k3),
        .busy(busy3), .done(done3), .X_POST(xp3)
    );

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] exp_q2[$];
    logic [3*N-1:0] exp_q3[$];
    logic [2*N-1:0] last_exp;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [N-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [N-1:0] red(input longint v);
`ifdef POST_STATE_SAT_EN
        if (v > MAXV) return N'(MAXV);
        if (v < MINV) return N'(MINV);
`endif
        return v[N-1:0];
    endfunction

    // x_post[i] = reduce(floor((x[i]*2^FRAC + sum_j K(i,j)*e[j]) / 2^FRAC))
    function automatic logic [2*N-1:0] model2(input logic [2*N-1:0] x, input logic [2*N-1:0] z,
                                               input logic [2*N-1:0] zh, input logic [4*N-1:0] kk);
        logic [2*N-1:0] r;
        longint acc, e;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            acc = 0;
            for (int j = 0; j < 2; j++) begin
                e = sx(red(sx(z[j*N +: N]) - sx(zh[j*N +: N])));
                acc += sx(kk[(i*2+j)*N +: N]) * e;
            end
            r[i*N +: N] = red(((sx(x[i*N +: N]) <<< FRAC) + acc) >>> FRAC);
        end
        return r;
    endfunction

    // Scoreboard monitor for the 2x2 instance.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q2.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                logic [2*N-1:0] e;
                e = exp_q2.pop_front();
                chk("xpost_row0", sx(X_POST[0 +: N]), sx(e[0 +: N]));
                chk("xpost_row1", sx(X_POST[N +: N]), sx(e[N +: N]));
            end
        end
    end

    // Scoreboard monitor for the 3x1 instance.
    always @(negedge clk) begin
        if (rst_n && done3) begin
            if (exp_q3.size() == 0) begin
                chk("unexpected_done3", 1, 0);
            end else begin
                logic [3*N-1:0] e;
                e = exp_q3.pop_front();
                for (int i = 0; i < 3; i++)
                    chk("xpost3_row", sx(xp3[i*N +: N]), sx(e[i*N +: N]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        chk(name, cyc, 7);
    endtask

    task automatic set_in(input longint x0, input longint x1, input longint z0, input longint z1,
                          input longint h0, input longint h1, input longint k00, input longint k01,
                          input longint k10, input longint k11);
        x_prior = {N'(x1), N'(x0)};
        z_meas  = {N'(z1), N'(z0)};
        z_hat   = {N'(h1), N'(h0)};
        k       = {N'(k11), N'(k10), N'(k01), N'(k00)};
    endtask

    function automatic logic [N-1:0] rnd();
        if ($urandom_range(0, 1) == 1)
            return N'($urandom);
        return N'($urandom_range(0, 4095) - 2048);
    endfunction

    task automatic rand_in();
        for (int i = 0; i < 2; i++) begin
            x_prior[i*N +: N] = rnd();
            z_meas[i*N +: N]  = rnd();
            z_hat[i*N +: N]   = rnd();
        end
        for (int i = 0; i < 4; i++)
            k[i*N +: N] = rnd();
    endtask

    task automatic run2(input string name);
        logic [2*N-1:0] e;
        e = model2(x_prior, z_meas, z_hat, k);
        exp_q2.push_back(e);
        last_exp = e;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        wait_done(name);
    endtask

    initial begin
        logic [2*N-1:0] prev, eab;
        int ndone;
        start = 0; abort = 0; x_prior = '0; z_meas = '0; z_hat = '0; k = '0;
        start3 = 0; abort3 = 0; x3 = '0; k3 = '0; z3 = '0; zh3 = '0;
        last_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_xpost", longint'(X_POST), 0);
        chk("reset_xpost3", longint'(xp3), 0);
        rst_n = 1'b1;
        step();

        // Nominal
        set_in(1024, 2048, 3072, 1024, 2048, 1024, 512, 256, 256, 512);
        run2("lat_nominal");
        chk("nominal_row0", sx(X_POST[0 +: N]), 1536);
        chk("nominal_row1", sx(X_POST[N +: N]), 2304);
        step();

        // Negative innovation
        set_in(0, 0, -1024, 0, 0, 0, 512, 0, 0, 0);
        run2("lat_negative");
        chk("negative_row0", sx(X_POST[0 +: N]), -512);
        chk("negative_row1", sx(X_POST[N +: N]), 0);
        step();

        // Overflow of the output selection
        set_in(524287, 0, 1024, 0, 0, 0, 1024, 0, 0, 0);
        run2("lat_overflow");
`ifdef POST_STATE_SAT_EN
        chk("overflow_row0", sx(X_POST[0 +: N]), 524287);
`else
        chk("overflow_row0", sx(X_POST[0 +: N]), -523265);
`endif
        step();

        // Handshake: extra start at cycle 2 ignored, inputs changed at cycle 3,
        // new start at cycle 7 (done cycle) accepted.
        set_in(1024, 2048, 3072, 1024, 2048, 1024, 512, 256, 256, 512);
        exp_q2.push_back(model2(x_prior, z_meas, z_hat, k));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        rand_in();
        repeat (4) step();
        chk("hs_done_at_7", done, 1);
        chk("hs_busy_low_at_done", busy, 0);
        set_in(0, 0, -1024, 0, 0, 0, 512, 0, 0, 0);
        run2("lat_back_to_back");
        step();

        // Abort during the second row's MAC
        prev = last_exp;
        set_in(1024, 2048, 3072, 1024, 2048, 1024, 512, 256, 256, 512);
        eab = model2(x_prior, z_meas, z_hat, k);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_low", busy, 0);
        chk("abort_row0_new", sx(X_POST[0 +: N]), sx(eab[0 +: N]));
        chk("abort_row1_kept", sx(X_POST[N +: N]), sx(prev[N +: N]));
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) ndone++;
            step();
        end
        chk("abort_no_done", ndone, 0);

        // Asynchronous reset mid-MAC
        rand_in();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_xpost", longint'(X_POST), 0);
        step();
        rst_n = 1'b1;
        step();

        // Randomised runs, some issued in the done cycle
        for (int t = 0; t < 25; t++) begin
            rand_in();
            run2("lat_random");
            if ($urandom_range(0, 1) == 1) step();
        end
        step();

        // Alternate shape NX=3, NZ=1
        x3  = '0;
        z3  = N'(512);
        zh3 = '0;
        k3  = {N'(-1024), N'(2048), N'(1024)};
        exp_q3.push_back({N'(-512), N'(1024), N'(512)});
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!done3 && cyc < 40) begin
                step();
                cyc++;
            end
            chk("lat_shape3", cyc, 7);
        end
        chk("shape3_row2", sx(xp3[2*N +: N]), -512);
        repeat (3) step();

        chk("queue2_drained", exp_q2.size(), 0);
        chk("queue3_drained", exp_q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
